// File: rtl/px_seq_pkg.sv
// Shared definitions for the P-M responder sequencer: one-hot state indices,
// phase encoding and the next-state request priority order.
package px_seq_pkg;

   localparam int N_ST = 13;

   // Bit positions of the one-hot CPU state register
   localparam logic [3:0] ST_P0 = 4'd0;
   localparam logic [3:0] ST_P1 = 4'd1;
   localparam logic [3:0] ST_P2 = 4'd2;
   localparam logic [3:0] ST_P3 = 4'd3;
   localparam logic [3:0] ST_P4 = 4'd4;
   localparam logic [3:0] ST_P5 = 4'd5;
   localparam logic [3:0] ST_K1 = 4'd6;
   localparam logic [3:0] ST_K2 = 4'd7;
   localparam logic [3:0] ST_I1 = 4'd8;
   localparam logic [3:0] ST_I2 = 4'd9;
   localparam logic [3:0] ST_I3 = 4'd10;
   localparam logic [3:0] ST_I4 = 4'd11;
   localparam logic [3:0] ST_I5 = 4'd12;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_S1,
      PH_GAP,
      PH_WAIT,
      PH_S2,
      PH_END1,
      PH_END2
   } phase_e;

   // Highest priority first. I1 is only ever requested by si1, which ranks below sp0/sp1.
   localparam logic [3:0] PRIO_ORDER [N_ST] = '{
      ST_K2, ST_K1, ST_P0, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5,
      ST_I1, ST_I2, ST_I3, ST_I4, ST_I5
   };

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/px_prio.sv
// Combinational priority pick over state-indexed request lines: one-hot winner,
// any-request flag and a flag for more than one simultaneous request.
module px_prio
   import px_seq_pkg::*;
(
   input  logic [N_ST-1:0] req,
   output logic [N_ST-1:0] sel,
   output logic            any,
   output logic            multi
);

   // Walk from lowest to highest priority so the last hit wins.
   always_comb begin
      sel = '0;
      for (int i = N_ST - 1; i >= 0; i--) begin
         if (req[PRIO_ORDER[i]]) sel = N_ST'(1) << PRIO_ORDER[i];
      end
   end

   assign any   = |req;
   assign multi = $countones(req) > 1;

endmodule

// File: rtl/px_seq.sv
// P-M responder: one-hot CPU state register plus strob1/strob2 cycle timing.
// Strobes and ekc pulses are registered; cycle length stretches while waiting for got.
module px_seq
   import px_seq_pkg::*;
#(
   parameter int S1_TICKS  = 3,
   parameter int S2_TICKS  = 3,
   parameter int GAP_TICKS = 1
)(
   input  logic __clk,
   input  logic clm,
   input  logic sp0,
   input  logic sp1,
   input  logic si1,
   input  logic ep0,
   input  logic ep1,
   input  logic ep2,
   input  logic ep3,
   input  logic ep4,
   input  logic ep5,
   input  logic ek1,
   input  logic ek2,
   input  logic ei2,
   input  logic ei3,
   input  logic ei4,
   input  logic ei5,
   input  logic sgl,
   input  logic mem,
   input  logic got,
   output logic p0,
   output logic p1,
   output logic p2,
   output logic p3,
   output logic p4,
   output logic p5,
   output logic k1,
   output logic k2,
   output logic i1,
   output logic i2,
   output logic i3,
   output logic i4,
   output logic i5,
   output logic strob1,
   output logic strob2,
   output logic ekc_1,
   output logic ekc_2,
   output logic busy,
   output logic multi
);

   localparam int CW = $clog2(max3(S1_TICKS, S2_TICKS, GAP_TICKS) + 1);

   phase_e          phase, phase_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [N_ST-1:0] state, state_nxt;
   logic            multi_nxt;

   logic [N_ST-1:0] req_vec, req_sel, start_vec, start_sel;
   logic            req_any, req_multi, start_any, start_multi;

   // Concatenation order follows the ST_* bit positions (I1 has no request line).
   assign req_vec   = {ei5, ei4, ei3, ei2, 1'b0, ek2, ek1, ep5, ep4, ep3, ep2, ep1, ep0};
   assign start_vec = {4'b0, si1, 6'b0, sp1, sp0};

   px_prio u_req_prio (
      .req   (req_vec),
      .sel   (req_sel),
      .any   (req_any),
      .multi (req_multi)
   );

   px_prio u_start_prio (
      .req   (start_vec),
      .sel   (start_sel),
      .any   (start_any),
      .multi (start_multi)
   );

   always_ff @(posedge __clk or posedge clm) begin
      if (clm) begin
         phase  <= PH_IDLE;
         cnt    <= '0;
         state  <= '0;
         strob1 <= 1'b0;
         strob2 <= 1'b0;
         ekc_1  <= 1'b0;
         ekc_2  <= 1'b0;
         busy   <= 1'b0;
         multi  <= 1'b0;
      end else begin
         phase  <= phase_nxt;
         cnt    <= cnt_nxt;
         state  <= state_nxt;
         strob1 <= (phase_nxt == PH_S1);
         strob2 <= (phase_nxt == PH_S2);
         ekc_1  <= (phase_nxt == PH_END1);
         ekc_2  <= (phase_nxt == PH_END2);
         busy   <= (phase_nxt != PH_IDLE);
         multi  <= multi_nxt;
      end
   end

   // cnt holds the remaining ticks of the current phase minus one.
   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt;
      state_nxt = state;
      multi_nxt = multi;
      unique case (phase)
         PH_IDLE: begin
            if (start_any) begin
               state_nxt = start_sel;
               multi_nxt = multi | start_multi;
               phase_nxt = PH_S1;
               cnt_nxt   = CW'(S1_TICKS - 1);
            end
         end
         PH_S1: begin
            if (cnt == '0) begin
               if (sgl) begin
                  phase_nxt = PH_END1;
                  cnt_nxt   = '0;
               end else begin
                  phase_nxt = PH_GAP;
                  cnt_nxt   = CW'(GAP_TICKS - 1);
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         PH_GAP: begin
            if (cnt == '0) begin
               if (mem) begin
                  phase_nxt = PH_WAIT;
                  cnt_nxt   = '0;
               end else begin
                  phase_nxt = PH_S2;
                  cnt_nxt   = CW'(S2_TICKS - 1);
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         PH_WAIT: begin
            if (got) begin
               phase_nxt = PH_S2;
               cnt_nxt   = CW'(S2_TICKS - 1);
            end
         end
         PH_S2: begin
            if (cnt == '0) begin
               phase_nxt = PH_END2;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         PH_END1, PH_END2: begin
            multi_nxt = multi | req_multi;
            if (req_any) begin
               state_nxt = req_sel;
               phase_nxt = PH_S1;
               cnt_nxt   = CW'(S1_TICKS - 1);
            end else begin
               state_nxt = '0;
               phase_nxt = PH_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = '0;
            phase_nxt = PH_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign p0 = state[ST_P0];
   assign p1 = state[ST_P1];
   assign p2 = state[ST_P2];
   assign p3 = state[ST_P3];
   assign p4 = state[ST_P4];
   assign p5 = state[ST_P5];
   assign k1 = state[ST_K1];
   assign k2 = state[ST_K2];
   assign i1 = state[ST_I1];
   assign i2 = state[ST_I2];
   assign i3 = state[ST_I3];
   assign i4 = state[ST_I4];
   assign i5 = state[ST_I5];

endmodule

// File: tb/tb_px_seq.sv
// Bench for px_seq: cycle-position reference model checked every clock, directed
// scenarios with hand-counted expectations, then randomized traffic.
module tb_px_seq;

   localparam int S1 = 3;
   localparam int S2 = 3;
   localparam int G  = 1;
   localparam int BIG = 1 << 30;
   // Request lines in priority order (index 0 = ek2) mapped to state bit positions.
   localparam int REQ_ST [12] = '{7, 6, 0, 1, 2, 3, 4, 5, 9, 10, 11, 12};

   logic clk = 1'b0;
   logic clm = 1'b1;
   logic sp0 = 0, sp1 = 0, si1 = 0;
   logic ep0 = 0, ep1 = 0, ep2 = 0, ep3 = 0, ep4 = 0, ep5 = 0;
   logic ek1 = 0, ek2 = 0, ei2 = 0, ei3 = 0, ei4 = 0, ei5 = 0;
   logic sgl = 0, mem = 0, got = 0;
   logic p0, p1, p2, p3, p4, p5, k1, k2, i1, i2, i3, i4, i5;
   logic strob1, strob2, ekc_1, ekc_2, busy, multi;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   px_seq #(.S1_TICKS(S1), .S2_TICKS(S2), .GAP_TICKS(G)) dut (
      .__clk(clk), .clm(clm),
      .sp0(sp0), .sp1(sp1), .si1(si1),
      .ep0(ep0), .ep1(ep1), .ep2(ep2), .ep3(ep3), .ep4(ep4), .ep5(ep5),
      .ek1(ek1), .ek2(ek2), .ei2(ei2), .ei3(ei3), .ei4(ei4), .ei5(ei5),
      .sgl(sgl), .mem(mem), .got(got),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5),
      .k1(k1), .k2(k2), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5),
      .strob1(strob1), .strob2(strob2), .ekc_1(ekc_1), .ekc_2(ekc_2),
      .busy(busy), .multi(multi)
   );

   function automatic logic [18:0] dut_vec();
      return {i5, i4, i3, i2, i1, k2, k1, p5, p4, p3, p2, p1, p0,
              strob1, strob2, ekc_1, ekc_2, busy, multi};
   endfunction

   // Reference model: current state index (-1 = idle), clocks since cycle start,
   // whether the cycle has a second strobe, and where strob2 begins.
   int   m_st = -1;
   int   m_pos = 0;
   bit   m_two = 0;
   bit   m_mem = 0;
   int   m_s2s = BIG;
   bit   m_multi = 0;

   task automatic new_cycle();
      m_pos = 0;
      m_two = 0;
      m_mem = 0;
      m_s2s = BIG;
   endtask

   function automatic logic [18:0] model_out();
      logic [12:0] st;
      logic s1, s2, e1, e2, b;
      st = '0; s1 = 0; s2 = 0; e1 = 0; e2 = 0; b = 0;
      if (m_st >= 0) begin
         st = 13'(1) << m_st;
         b  = 1;
         s1 = m_pos < S1;
         e1 = !m_two && m_pos == S1;
         s2 = m_two && m_pos >= m_s2s && m_pos < m_s2s + S2;
         e2 = m_two && m_pos == m_s2s + S2;
      end
      return {st, s1, s2, e1, e2, b, m_multi};
   endfunction

   task automatic model_step();
      int n;
      int pick;
      logic [11:0] rq;
      if (m_st < 0) begin
         n = int'(sp0) + int'(sp1) + int'(si1);
         if (n > 0) begin
            m_st = sp0 ? 0 : (sp1 ? 1 : 8);
            if (n > 1) m_multi = 1;
            new_cycle();
         end
      end else if ((!m_two && m_pos == S1) || (m_two && m_pos == m_s2s + S2)) begin
         rq = {ei5, ei4, ei3, ei2, ep5, ep4, ep3, ep2, ep1, ep0, ek1, ek2};
         pick = -1;
         n = 0;
         for (int i = 11; i >= 0; i--) begin
            if (rq[i]) begin
               pick = i;
               n++;
            end
         end
         if (n > 1) m_multi = 1;
         m_st = (pick < 0) ? -1 : REQ_ST[pick];
         new_cycle();
      end else begin
         if (m_pos == S1 - 1) m_two = !sgl;
         if (m_two && m_pos == S1 + G - 1) begin
            m_mem = mem;
            if (!mem) m_s2s = S1 + G;
         end else if (m_two && m_mem && m_s2s == BIG && m_pos >= S1 + G && got) begin
            m_s2s = m_pos + 1;
         end
         m_pos++;
      end
   endtask

   always @(posedge clk or posedge clm) begin
      if (clm) begin
         m_st = -1;
         m_multi = 0;
         new_cycle();
      end else begin
         model_step();
      end
   end

   logic [18:0] cmp_exp, cmp_act;
   always @(negedge clk) begin
      if (!clm) begin
         cmp_exp = model_out();
         cmp_act = dut_vec();
         checks++;
         if (cmp_act !== cmp_exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t dut=%05h model=%05h", $time, cmp_act, cmp_exp);
         end
         checks++;
         if (strob1 && strob2) begin
            errors++;
            $display("FAIL strobe_overlap t=%0t strob1=%b strob2=%b required not both 1",
                     $time, strob1, strob2);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      {sp0, sp1, si1} = '0;
      {ep0, ep1, ep2, ep3, ep4, ep5} = '0;
      {ek1, ek2, ei2, ei3, ei4, ei5} = '0;
      {sgl, mem, got} = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 clm = 1;
      clear_inputs();
      @(negedge clk);
      #2 clm = 0;
   endtask

   // which: 1 = ekc_1, 2 = ekc_2, 3 = strob2
   task automatic wait_sig(input int which, input string nm);
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if ((which == 1 && ekc_1) || (which == 2 && ekc_2) || (which == 3 && strob2))
            seen = 1;
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   task automatic pulse_start(input int which);
      @(negedge clk);
      if (which == 0) sp0 = 1; else if (which == 1) sp1 = 1; else si1 = 1;
      @(negedge clk);
      {sp0, sp1, si1} = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_p0, n_s1, n_e1, n_i2, n_i3, n_i5, k;
      bit prev_e;
      logic [11:0] r;

      clear_inputs();
      repeat (3) @(negedge clk);
      chk("reset_state", 32'(dut_vec()), 32'd0);
      #2 clm = 0;

      // Reset during strob2 of a two-strobe cycle, then a clean restart
      sgl = 0; mem = 0;
      pulse_start(1);
      wait_sig(3, "t1_reach_s2");
      #2 clm = 1;
      #1 chk("t1_async_clear", 32'(dut_vec()), 32'd0);
      @(negedge clk);
      #2 clm = 0;
      sgl = 1;
      pulse_start(1);
      chk("t1_restart_p1", 32'({p1, busy, strob1}), 32'b111);
      repeat (6) @(negedge clk);

      // Single-strobe P0 cycle with no follow-on request
      do_reset();
      sgl = 1;
      @(negedge clk);
      sp0 = 1;
      n_p0 = 0; n_s1 = 0; n_e1 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) sp0 = 0;
         n_p0 += int'(p0);
         n_s1 += int'(strob1);
         n_e1 += int'(ekc_1);
      end
      chk("t2_p0_clocks", 32'(n_p0), 32'd4);
      chk("t2_strob1_clocks", 32'(n_s1), 32'd3);
      chk("t2_ekc1_clocks", 32'(n_e1), 32'd1);
      chk("t2_idle_after", 32'({busy, p0}), 32'b00);

      // Memory-wait cycle then hand-off to P4
      do_reset();
      sgl = 0; mem = 1; ep4 = 1;
      pulse_start(1);
      for (int i = 0; i < 20 && strob1; i++) @(negedge clk);
      chk("t3_gap_reached", 32'(strob1), 32'd0);
      repeat (5) @(negedge clk);
      chk("t3_waiting", 32'({strob1, strob2, busy, p1}), 32'b0011);
      got = 1;
      @(negedge clk);
      chk("t3_strob2_after_got", 32'(strob2), 32'd1);
      got = 0;
      wait_sig(2, "t3_ekc2");
      @(negedge clk);
      chk("t3_p4_s1", 32'({p4, strob1, p1}), 32'b110);
      ep4 = 0; sgl = 1;
      repeat (6) @(negedge clk);

      // Two simultaneous requests at END
      do_reset();
      sgl = 1; ep3 = 1; ek1 = 1;
      pulse_start(0);
      wait_sig(1, "t4_ekc1");
      @(negedge clk);
      chk("t4_k1_wins", 32'({k1, p3, multi}), 32'b101);
      ep3 = 0; ek1 = 0;
      repeat (8) @(negedge clk);
      chk("t4_multi_sticky", 32'({multi, busy}), 32'b10);
      do_reset();
      @(negedge clk);
      chk("t4_multi_cleared", 32'(multi), 32'd0);

      // Start pulse ignored mid-cycle
      do_reset();
      sgl = 1;
      pulse_start(1);
      sp0 = 1;
      @(negedge clk);
      sp0 = 0;
      chk("t5_sp0_ignored", 32'({p1, p0, strob1}), 32'b101);
      repeat (6) @(negedge clk);

      // Chain P0 -> I2 -> I3 -> I5 -> idle
      do_reset();
      sgl = 1; ei2 = 1;
      pulse_start(0);
      n_i2 = 0; n_i3 = 0; n_i5 = 0; k = 0; prev_e = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (prev_e) begin
            k++;
            ei2 = 0;
            ei3 = (k == 1);
            ei5 = (k == 2);
         end
         prev_e = ekc_1;
         n_i2 += int'(i2);
         n_i3 += int'(i3);
         n_i5 += int'(i5);
      end
      chk("t6_i2_clocks", 32'(n_i2), 32'd4);
      chk("t6_i3_clocks", 32'(n_i3), 32'd4);
      chk("t6_i5_clocks", 32'(n_i5), 32'd4);
      chk("t6_idle_end", 32'({busy, multi}), 32'b00);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(0, 399) == 0) begin
            clm = 1;
            @(negedge clk);
            #1 clm = 0;
         end
         sgl = ($urandom_range(0, 1) == 1);
         mem = ($urandom_range(0, 1) == 1);
         got = ($urandom_range(0, 3) == 0);
         sp0 = ($urandom_range(0, 5) == 0);
         sp1 = ($urandom_range(0, 5) == 0);
         si1 = ($urandom_range(0, 5) == 0);
         r = 12'($urandom & $urandom & $urandom);
         {ei5, ei4, ei3, ei2, ep5, ep4, ep3, ep2, ep1, ep0, ek1, ek2} = r;
      end
      clear_inputs();
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/px_seq.md
Name: px_seq

Overview:
- Responder side of the P-M transition interface.
- Consumes the state-entry pulses (sp0, sp1, si1) and next-state requests (ep0..ep5, ek1, ek2, ei2..ei5) that P-M and the interrupt logic raise.
- Holds the one-hot CPU state register (P0..P5, K1, K2, I1..I5) and generates the strob1/strob2 timing of each cycle.
- Signals end-of-cycle back to P-M via ekc_1/ekc_2.

Parameters:
S1_TICKS, 3, clock cycles strob1 is held high (>=1)
S2_TICKS, 3, clock cycles strob2 is held high (>=1)
GAP_TICKS, 1, dead cycles between strob1 end and strob2 start (>=1)

Ports:
__clk  in  1  system clock
clm  in  1  reset: asynchronous, active-high
sp0  in  1  start pulse: enter P0 from idle
sp1  in  1  start pulse: enter P1 from idle
si1  in  1  start pulse: enter I1 from idle
ep0..ep5  in  1 each  next-state request P0..P5
ek1, ek2  in  1 each  next-state request K1, K2
ei2..ei5  in  1 each  next-state request I2..I5
sgl  in  1  current cycle is single-strobe (ends after strob1)
mem  in  1  current cycle waits for memory reply before strob2
got  in  1  memory reply (level, sampled)
p0..p5, k1, k2, i1..i5  out  1 each  one-hot state outputs
strob1  out  1  first strobe
strob2  out  1  second strobe
ekc_1  out  1  one-cycle pulse: cycle ended after strob1
ekc_2  out  1  one-cycle pulse: cycle ended after strob2
busy  out  1  a cycle is in progress
multi  out  1  sticky: >1 next-state request seen at cycle end; cleared by clm only

Behaviour:
Reset (clm=1, any time, asynchronous):
- All state outputs 0; strob1, strob2, ekc_1, ekc_2, busy, multi all 0; phase IDLE; tick counter 0.
- A cycle in progress is abandoned with no ekc pulse.

Phases: IDLE -> S1 -> (END1 | GAP -> [WAITMEM] -> S2 -> END2) -> next.

IDLE:
- busy=0, no state bit set.
- On the first edge with sp0, sp1 or si1 high, load P0, P1 or I1 respectively and enter S1.
- If several start pulses are high together, priority is sp0 > sp1 > si1 and multi is set.

S1:
- strob1=1 for exactly S1_TICKS cycles.
- Then: if sgl (sampled on the last S1 tick) go to END1, else go to GAP.

GAP:
- GAP_TICKS cycles with both strobes low.
- Then: if mem go to WAITMEM, else go to S2.

WAITMEM:
- Strobes low; stay until got=1 is sampled, then go to S2 on the next cycle.
- No timeout.

S2:
- strob2=1 for exactly S2_TICKS cycles, then go to END2.

END1 / END2:
- Single cycle; ekc_1 / ekc_2 = 1 respectively.
- Request inputs are sampled this cycle. The new state is loaded on the same edge that leaves END.
- Priority: ek2 > ek1 > ep0 > ep1 > ep2 > ep3 > ep4 > ep5 > ei2 > ei3 > ei4 > ei5. More than one request high sets multi.
- A winning request loads that state and the next cycle starts at S1, so busy stays 1.
- No request: clear all state bits and go to IDLE (busy=0 on the next cycle).

Start pulses:
- sp0/sp1/si1 are ignored whenever the phase is not IDLE.

State outputs:
- The state register changes only on entry from IDLE, at END, or on reset.
- State outputs are stable across the whole cycle, including both strobes.

Timing and counters:
- Minimum cycle length: single-strobe S1_TICKS+1 clocks; two-strobe without wait S1_TICKS+GAP_TICKS+S2_TICKS+1 clocks.
- Tick counter width is clog2(max(S1_TICKS, S2_TICKS, GAP_TICKS)+1). The counter is reloaded on every phase entry and never wraps.
- Strobes are registered outputs; strob1 and strob2 are never high simultaneously.

Decomposition:
- Shared package holds:
  - state index constants (ST_P0..ST_P5, ST_K1, ST_K2, ST_I1..ST_I5, 13 bits one-hot);
  - phase encoding (PH_IDLE, PH_S1, PH_GAP, PH_WAIT, PH_S2, PH_END1, PH_END2);
  - the request priority order.
- One natural sub-module: px_prio, a combinational priority encoder from the 12 request lines to one-hot next state plus a multi flag. It is reused for the start-pulse priority.

Test Plan:
- Reset mid-S2 (clm pulse during strob2) -> all outputs 0 immediately, no ekc, phase IDLE; a subsequent sp1 starts P1 normally.
- sp0, sgl=1, defaults, no requests at END -> p0=1 for 4 clocks, strob1 high 3 clocks, ekc_1 one clock, then p0=0, busy=0.
- sp1, sgl=0, mem=1, got raised 5 clocks after GAP, ep4 at END -> strob2 starts 1 clock after got sampled; ekc_2 pulses; p4=1 on the next clock with strob1 following immediately.
- ep3 and ek1 both high at END -> k1 loaded, multi=1 and stays 1 until clm.
- sp0 pulsed during S1 of a P1 cycle -> ignored, p1 remains, no state change.
- Chain ei2 -> ei3 -> ei5 -> none with sgl=1 -> i2, i3, i5 each held exactly 4 clocks, then busy=0; strob1 and strob2 never overlap (assertion across whole run).
